// File: rtl/tt_vpu_ovi_pkg.sv
// Shared types and constants for the vector-load OVI side of the scoreboard drain handshake.
package tt_vpu_ovi_pkg;

  localparam int LQ_DEPTH = 8;
  localparam int LQID_W   = $clog2(LQ_DEPTH);

  typedef logic [LQID_W-1:0] lqid_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/tt_load_drain_ovi.sv
// Load buffer that holds returned vector-load data per LQ entry and streams a completed
// load's entries, in lqid order, to VRF writeback when the scoreboard requests a drain.
module tt_load_drain_ovi #(
  parameter int LQ_DEPTH = tt_vpu_ovi_pkg::LQ_DEPTH,
  parameter int DATA_W   = 512,
  parameter int LQID_W   = $clog2(LQ_DEPTH),
  parameter int CNT_W    = LQID_W + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_drain_load_buffer,
  input  logic [CNT_W-1:0]    i_drain_ref_count,
  input  logic [LQID_W-1:0]   i_drain_lqid_start,
  output logic                o_draining_load_buffer,
  input  logic                i_ld_data_valid,
  input  logic [LQID_W-1:0]   i_ld_data_lqid,
  input  logic [DATA_W-1:0]   i_ld_data,
  output logic                o_wb_valid,
  output logic [LQID_W-1:0]   o_wb_lqid,
  output logic [DATA_W-1:0]   o_wb_data,
  input  logic                i_wb_ready,
  output logic                o_lq_commit,
  output logic [LQID_W-1:0]   o_dest_lqid,
  output logic [LQ_DEPTH-1:0] o_entry_ready,
  output logic                o_protocol_err
);

  import tt_vpu_ovi_pkg::*;

  drain_state_e        r_state;
  drain_state_e        w_state_next;
  logic [LQID_W-1:0]   r_cur_lqid;
  logic [LQID_W-1:0]   w_cur_lqid_next;
  logic [CNT_W-1:0]    r_remaining;
  logic [CNT_W-1:0]    w_remaining_next;
  logic [LQ_DEPTH-1:0] r_ready;
  logic [LQ_DEPTH-1:0] w_ready_next;
  logic                r_protocol_err;
  logic [DATA_W-1:0]   r_data [LQ_DEPTH];

  logic w_draining;
  logic w_wb_valid;
  logic w_fire;

  assign w_draining = (r_state == DRAIN);
  assign w_wb_valid = w_draining && r_ready[r_cur_lqid];
  assign w_fire     = w_wb_valid && i_wb_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cur_lqid     <= '0;
      r_remaining    <= '0;
      r_ready        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cur_lqid  <= w_cur_lqid_next;
      r_remaining <= w_remaining_next;
      r_ready     <= w_ready_next;
      if (i_ld_data_valid && r_ready[i_ld_data_lqid]) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // Data array is left unreset so it can later be swapped for an SRAM macro.
  always_ff @(posedge clk) begin
    if (i_ld_data_valid) begin
      r_data[i_ld_data_lqid] <= i_ld_data;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cur_lqid_next  = r_cur_lqid;
    w_remaining_next = r_remaining;
    case (r_state)
      IDLE: begin
        if (i_drain_load_buffer) begin
          w_cur_lqid_next  = i_drain_lqid_start;
          w_remaining_next = i_drain_ref_count;
          if (i_drain_ref_count != '0) begin
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_fire) begin
          w_cur_lqid_next  = r_cur_lqid + LQID_W'(1);
          w_remaining_next = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1)) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // A fill landing on the entry being retired wins, so the set is applied after the clear.
  always_comb begin
    w_ready_next = r_ready;
    if (w_fire) begin
      w_ready_next[r_cur_lqid] = 1'b0;
    end
    if (i_ld_data_valid) begin
      w_ready_next[i_ld_data_lqid] = 1'b1;
    end
  end

  assign o_draining_load_buffer = w_draining;
  assign o_wb_valid             = w_wb_valid;
  assign o_wb_lqid              = w_draining ? r_cur_lqid : '0;
  assign o_wb_data              = w_draining ? r_data[r_cur_lqid] : '0;
  assign o_lq_commit            = w_fire;
  assign o_dest_lqid            = w_fire ? r_cur_lqid : '0;
  assign o_entry_ready          = r_ready;
  assign o_protocol_err         = r_protocol_err;

endmodule

// File: tb/tb_tt_load_drain_ovi.sv
// Directed self-checking bench for tt_load_drain_ovi: fills, drains, wrap, stalls,
// zero/full-depth requests, protocol error and asynchronous reset mid-drain.
module tb_tt_load_drain_ovi;

  localparam int LQ_DEPTH = 8;
  localparam int DATA_W   = 512;
  localparam int LQID_W   = 3;
  localparam int CNT_W    = 4;

  logic                clk;
  logic                reset_n;
  logic                drainReq;
  logic [CNT_W-1:0]    drainCount;
  logic [LQID_W-1:0]   drainStart;
  logic                draining;
  logic                ldValid;
  logic [LQID_W-1:0]   ldLqid;
  logic [DATA_W-1:0]   ldData;
  logic                wbValid;
  logic [LQID_W-1:0]   wbLqid;
  logic [DATA_W-1:0]   wbData;
  logic                wbReady;
  logic                lqCommit;
  logic [LQID_W-1:0]   destLqid;
  logic [LQ_DEPTH-1:0] entryReady;
  logic                protocolErr;

  int assertCount = 0;
  int failCount   = 0;

  tt_load_drain_ovi #(
    .LQ_DEPTH(LQ_DEPTH),
    .DATA_W  (DATA_W),
    .LQID_W  (LQID_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .i_drain_load_buffer   (drainReq),
    .i_drain_ref_count     (drainCount),
    .i_drain_lqid_start    (drainStart),
    .o_draining_load_buffer(draining),
    .i_ld_data_valid       (ldValid),
    .i_ld_data_lqid        (ldLqid),
    .i_ld_data             (ldData),
    .o_wb_valid            (wbValid),
    .o_wb_lqid             (wbLqid),
    .o_wb_data             (wbData),
    .i_wb_ready            (wbReady),
    .o_lq_commit           (lqCommit),
    .o_dest_lqid           (destLqid),
    .o_entry_ready         (entryReady),
    .o_protocol_err        (protocolErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mkData(input int k);
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) begin
      d[w*32 +: 32] = 32'hDA7A_0000 + 32'(k * 256 + w);
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge so new inputs can be driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [LQID_W-1:0] lqid, input int k);
    ldValid = 1'b1;
    ldLqid  = lqid;
    ldData  = mkData(k);
    tick();
    ldValid = 1'b0;
  endtask

  task automatic requestDrain(input logic [LQID_W-1:0] start, input logic [CNT_W-1:0] cnt);
    drainReq   = 1'b1;
    drainStart = start;
    drainCount = cnt;
    #1;
    checkOutput("capture_draining_low", DATA_W'(draining), DATA_W'(0));
    tick();
    drainReq = 1'b0;
  endtask

  task automatic checkCommit(input string tag, input logic [LQID_W-1:0] lqid, input int k);
    #1;
    checkOutput({tag, "_draining"}, DATA_W'(draining), DATA_W'(1));
    checkOutput({tag, "_wbvalid"},  DATA_W'(wbValid),  DATA_W'(1));
    checkOutput({tag, "_wblqid"},   DATA_W'(wbLqid),   DATA_W'(lqid));
    checkOutput({tag, "_wbdata"},   wbData,            mkData(k));
    checkOutput({tag, "_commit"},   DATA_W'(lqCommit), DATA_W'(1));
    checkOutput({tag, "_dest"},     DATA_W'(destLqid), DATA_W'(lqid));
  endtask

  task automatic checkIdle(input string tag, input logic [LQ_DEPTH-1:0] expReady);
    #1;
    checkOutput({tag, "_draining"}, DATA_W'(draining),   DATA_W'(0));
    checkOutput({tag, "_wbvalid"},  DATA_W'(wbValid),    DATA_W'(0));
    checkOutput({tag, "_commit"},   DATA_W'(lqCommit),   DATA_W'(0));
    checkOutput({tag, "_ready"},    DATA_W'(entryReady), DATA_W'(expReady));
  endtask

  initial begin
    logic [LQID_W-1:0] wrapOrder [4];
    wrapOrder[0] = 3'd6; wrapOrder[1] = 3'd7; wrapOrder[2] = 3'd0; wrapOrder[3] = 3'd1;

    reset_n    = 1'b0;
    drainReq   = 1'b0;
    drainCount = '0;
    drainStart = '0;
    ldValid    = 1'b0;
    ldLqid     = '0;
    ldData     = '0;
    wbReady    = 1'b0;
    #2;
    checkIdle("reset", 8'h00);
    checkOutput("reset_wblqid", DATA_W'(wbLqid), DATA_W'(0));
    checkOutput("reset_wbdata", wbData, DATA_W'(0));
    checkOutput("reset_dest", DATA_W'(destLqid), DATA_W'(0));
    checkOutput("reset_err", DATA_W'(protocolErr), DATA_W'(0));
    #19 reset_n = 1'b1;
    tick();

    $display("[TB] basic drain 2,3,4");
    applyStimulus(3'd2, 10);
    applyStimulus(3'd3, 11);
    applyStimulus(3'd4, 12);
    checkIdle("filled", 8'h1C);
    wbReady = 1'b1;
    requestDrain(3'd2, 4'd3);
    checkCommit("basic0", 3'd2, 10); tick();
    checkCommit("basic1", 3'd3, 11); tick();
    checkCommit("basic2", 3'd4, 12); tick();
    checkIdle("basic_done", 8'h00);

    $display("[TB] wrap drain 6,7,0,1");
    for (int i = 0; i < 4; i++) applyStimulus(wrapOrder[i], 20 + i);
    checkIdle("wrap_filled", 8'hC3);
    requestDrain(3'd6, 4'd4);
    for (int i = 0; i < 4; i++) begin
      checkCommit("wrap", wrapOrder[i], 20 + i);
      tick();
    end
    checkIdle("wrap_done", 8'h00);

    $display("[TB] missing entry stall");
    applyStimulus(3'd0, 30);
    requestDrain(3'd0, 4'd2);
    checkCommit("miss0", 3'd0, 30); tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("miss_draining", DATA_W'(draining), DATA_W'(1));
      checkOutput("miss_wbvalid", DATA_W'(wbValid), DATA_W'(0));
      checkOutput("miss_commit", DATA_W'(lqCommit), DATA_W'(0));
      tick();
    end
    ldValid = 1'b1; ldLqid = 3'd1; ldData = mkData(31);
    #1;
    checkOutput("nobypass_wbvalid", DATA_W'(wbValid), DATA_W'(0));
    checkOutput("nobypass_commit", DATA_W'(lqCommit), DATA_W'(0));
    tick();
    ldValid = 1'b0;
    checkCommit("miss1", 3'd1, 31); tick();
    checkIdle("miss_done", 8'h00);

    $display("[TB] writeback backpressure");
    applyStimulus(3'd3, 40);
    applyStimulus(3'd4, 41);
    wbReady = 1'b0;
    requestDrain(3'd3, 4'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_wbvalid", DATA_W'(wbValid), DATA_W'(1));
      checkOutput("bp_wblqid", DATA_W'(wbLqid), DATA_W'(3));
      checkOutput("bp_wbdata", wbData, mkData(40));
      checkOutput("bp_commit", DATA_W'(lqCommit), DATA_W'(0));
      checkOutput("bp_ready", DATA_W'(entryReady), DATA_W'(8'h18));
      tick();
    end
    wbReady = 1'b1;
    checkCommit("bp0", 3'd3, 40); tick();
    checkCommit("bp1", 3'd4, 41); tick();
    checkIdle("bp_done", 8'h00);

    $display("[TB] zero-count request");
    requestDrain(3'd1, 4'd0);
    checkIdle("zero0", 8'h00);
    tick();
    checkIdle("zero1", 8'h00);

    $display("[TB] full-depth drain from 5");
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 50 + i);
    checkIdle("full_filled", 8'hFF);
    requestDrain(3'd5, 4'd8);
    for (int i = 0; i < 8; i++) begin
      checkCommit("full", 3'((5 + i) % 8), 50 + ((5 + i) % 8));
      tick();
    end
    checkIdle("full_done", 8'h00);
    checkOutput("err_clean", DATA_W'(protocolErr), DATA_W'(0));

    $display("[TB] protocol error on double fill");
    applyStimulus(3'd2, 60);
    #1;
    checkOutput("err_single", DATA_W'(protocolErr), DATA_W'(0));
    applyStimulus(3'd2, 61);
    #1;
    checkOutput("err_set", DATA_W'(protocolErr), DATA_W'(1));
    tick(); tick();
    checkOutput("err_sticky", DATA_W'(protocolErr), DATA_W'(1));
    checkOutput("err_ready", DATA_W'(entryReady), DATA_W'(8'h04));

    $display("[TB] async reset mid-drain");
    applyStimulus(3'd3, 62);
    wbReady = 1'b0;
    requestDrain(3'd2, 4'd2);
    #1;
    checkOutput("mid_draining", DATA_W'(draining), DATA_W'(1));
    checkOutput("mid_wbdata", wbData, mkData(61));
    #1 reset_n = 1'b0;
    #1;
    checkIdle("async_reset", 8'h00);
    checkOutput("async_err", DATA_W'(protocolErr), DATA_W'(0));
    #3 reset_n = 1'b1;
    tick();
    checkIdle("post_reset", 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
